// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB manager arbiter with burst/lock aware handover and split address/data steering
module ahb_arbiter #(
  parameter int NO_OF_MANAGERS = 3,
  parameter int MASTER_BITS = $clog2(NO_OF_MANAGERS),
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  input  logic [NO_OF_MANAGERS-1:0]            HBUSREQ,
  input  logic [NO_OF_MANAGERS-1:0]            HLOCK,
  input  logic [NO_OF_MANAGERS*ADDR_WIDTH-1:0] M_HADDR,
  input  logic [2*NO_OF_MANAGERS-1:0]          M_HTRANS,
  input  logic [NO_OF_MANAGERS-1:0]            M_HWRITE,
  input  logic [3*NO_OF_MANAGERS-1:0]          M_HSIZE,
  input  logic [3*NO_OF_MANAGERS-1:0]          M_HBURST,
  input  logic [4*NO_OF_MANAGERS-1:0]          M_HPROT,
  input  logic [NO_OF_MANAGERS*DATA_WIDTH-1:0] M_HWDATA,
  input  logic                                 HREADY,
  output logic [NO_OF_MANAGERS-1:0]            HGRANT,
  output logic [MASTER_BITS-1:0]               HMASTER,
  output logic                                 HMASTLOCK,
  output logic [ADDR_WIDTH-1:0]                HADDR,
  output logic [1:0]                           HTRANS,
  output logic                                 HWRITE,
  output logic [2:0]                           HSIZE,
  output logic [2:0]                           HBURST,
  output logic [3:0]                           HPROT,
  output logic [DATA_WIDTH-1:0]                HWDATA
);
  localparam int N = NO_OF_MANAGERS;
  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR = 3'b001;
  typedef enum logic {NO_OWNER, OWNED} state_t;
  state_t state, state_nx;
  logic [N-1:0] grant_nx;
  logic [MASTER_BITS-1:0] master_nx, winner, data_owner;
  logic [3:0] remaining, remaining_nx;
  logic [1:0] own_trans;
  logic [2:0] own_burst;
  logic own_lock, owned, found, accepted, rearb;
  int m, d;
  assign m = int'(HMASTER);
  assign d = int'(data_owner);
  assign owned = state == OWNED;
  assign own_trans = M_HTRANS[2*m +: 2];
  assign own_burst = M_HBURST[3*m +: 3];
  assign own_lock = HLOCK[m];
  assign accepted = owned && HREADY && own_trans[1];
  assign rearb = HREADY && (!owned || (!own_lock && (own_trans == IDLE ||
                 (own_trans == NONSEQ && own_burst == SINGLE) ||
                 (own_trans == SEQ && remaining == 4'd1 && own_burst != INCR))));
  assign HADDR  = owned ? M_HADDR[ADDR_WIDTH*m +: ADDR_WIDTH] : '0;
  assign HTRANS = owned ? own_trans : IDLE;
  assign HWRITE = owned ? M_HWRITE[m] : 1'b0;
  assign HSIZE  = owned ? M_HSIZE[3*m +: 3] : 3'b000;
  assign HBURST = owned ? own_burst : 3'b000;
  assign HPROT  = owned ? M_HPROT[4*m +: 4] : 4'b0000;
  assign HWDATA = M_HWDATA[DATA_WIDTH*d +: DATA_WIDTH];
  // Remaining beats after the NONSEQ of a burst; INCR loads 0 and is never ended by the counter
  function automatic logic [3:0] beats_left(input logic [2:0] b);
    return b[2:1] == 2'd1 ? 4'd3 : b[2:1] == 2'd2 ? 4'd7 : b[2:1] == 2'd3 ? 4'd15 : 4'd0;
  endfunction
  // Round-robin scan starting after the current owner, the owner itself scanned last
  always_comb begin
    winner = HMASTER;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && HBUSREQ[(m + i) % N]) begin
        found = 1'b1;
        winner = MASTER_BITS'((m + i) % N);
      end
    end
  end
  // Next grant, owner, state and beat count
  always_comb begin
    remaining_nx = !accepted ? remaining : own_trans == NONSEQ ? beats_left(own_burst) :
                   remaining == 4'd0 ? 4'd0 : remaining - 4'd1;
    state_nx = !rearb ? state : found ? OWNED : NO_OWNER;
    grant_nx = !rearb ? HGRANT : found ? N'(1) << winner : '0;
    master_nx = rearb ? winner : HMASTER;
  end
  // Everything advances only on HREADY edges so a stalled transfer keeps its steering
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= NO_OWNER;
      HGRANT <= '0;
      HMASTER <= '0;
      data_owner <= '0;
      HMASTLOCK <= 1'b0;
      remaining <= '0;
    end else if (HREADY) begin
      state <= state_nx;
      HGRANT <= grant_nx;
      HMASTER <= master_nx;
      data_owner <= HMASTER;
      HMASTLOCK <= owned && own_lock;
      remaining <= remaining_nx;
    end
  end
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Multi-manager arbiter and manager-side multiplexer in front of the single-layer ahb_lite interconnect.
- Lets NO_OF_MANAGERS managers share one HADDR/HTRANS/HWDATA path into the decoder, mux and subordinates.
- Grants round-robin, respects fixed-length burst boundaries and HLOCK, and steers the address and data phases separately so that pipelined handover is correct.

Parameters:
- NO_OF_MANAGERS, 3, number of requesting managers (2..8).
- MASTER_BITS, $clog2(NO_OF_MANAGERS), width of HMASTER.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous active-low reset
- HBUSREQ  in  NO_OF_MANAGERS  per-manager bus request
- HLOCK  in  NO_OF_MANAGERS  per-manager locked-sequence request
- M_HADDR  in  NO_OF_MANAGERS*ADDR_WIDTH  packed manager addresses, manager i at slice i
- M_HTRANS  in  2*NO_OF_MANAGERS  packed HTRANS
- M_HWRITE  in  NO_OF_MANAGERS  packed HWRITE
- M_HSIZE  in  3*NO_OF_MANAGERS  packed HSIZE
- M_HBURST  in  3*NO_OF_MANAGERS  packed HBURST
- M_HPROT  in  4*NO_OF_MANAGERS  packed HPROT
- M_HWDATA  in  NO_OF_MANAGERS*DATA_WIDTH  packed write data
- HREADY  in  1  HREADY returned by the interconnect
- HGRANT  out  NO_OF_MANAGERS  one-hot grant, registered
- HMASTER  out  MASTER_BITS  address-phase owner index, registered
- HMASTLOCK  out  1  owner's transfer is locked
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT  out  ADDR_WIDTH/2/1/3/3/4  muxed address-phase signals to the interconnect
- HWDATA  out  DATA_WIDTH  muxed write data, selected by the data-phase owner

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous and active-low.
- Reset state: HGRANT=0, HMASTER=0, data owner=0, HMASTLOCK=0, state=NO_OWNER, beat counter=0, RR pointer=0.
- Address outputs during NO_OWNER: HTRANS=IDLE, all other address outputs 0.
- States:
  - NO_OWNER: no grant.
  - OWNED: exactly one HGRANT bit set; address outputs are a combinational mux of manager HMASTER.
- Accepted beat: owner HTRANS is NONSEQ or SEQ with HREADY=1 at the rising edge.
- Beat counter:
  - On an accepted NONSEQ, load remaining=beats-1: SINGLE=0; INCR4/WRAP4=3; INCR8/WRAP8=7; INCR16/WRAP16=15; INCR=0, treated as unbounded.
  - On an accepted SEQ, decrement.
  - Saturates at 0. BUSY does not change it.
- Rearbitration allowed at an edge with HREADY=1 when any one of these holds:
  - owner HTRANS=IDLE;
  - accepted NONSEQ SINGLE;
  - accepted SEQ with remaining=1 for a fixed burst;
  - state NO_OWNER.
- INCR (undefined length) is rearbitrated only when the owner drives IDLE.
- Lock: while owner HLOCK=1, rearbitration is suppressed regardless of the rules above. HMASTLOCK = registered HLOCK of the owner, updated on HREADY=1 edges.
- Selection:
  - Round-robin starting at (HMASTER+1) mod N, first HBUSREQ=1 wins.
  - The current owner is eligible again only after all others have been scanned.
  - A new winner updates HGRANT and HMASTER on the same edge. RR pointer = winner.
- No requests at a rearbitration point: go to NO_OWNER and drop HGRANT. HMASTER keeps its last value.
- HREADY=0: HGRANT, HMASTER, the counter and the data owner all hold, so a stalled transfer is never re-steered.
- Data phase: data owner <= HMASTER on every HREADY=1 edge. HWDATA = M_HWDATA[data owner] combinationally, so HWDATA follows the previous address owner during handover.
- Error handling: an owner that drives IDLE after an ERROR response cancels its burst, and rearbitration follows the IDLE rule.
- Simultaneous new requests: resolved by RR order only. Requests arriving mid-burst wait for the burst boundary.
- Reset asserted mid-burst: return to the reset state immediately.
- Grant width rule: HGRANT is always one-hot or zero.

Test Plan:
- Reset then HBUSREQ=3'b001, M0 NONSEQ SINGLE to addr 0x10 -> HGRANT=001 and HMASTER=0 one edge after the request; HADDR=0x10, HTRANS=NONSEQ.
- M0 INCR4 in progress, M1 requests at beat 2 -> HGRANT stays 001 for all 4 beats; switches to 010 on the HREADY=1 edge accepting beat 4; HWDATA shows M0 data for one further cycle.
- HBUSREQ=3'b111 held, every owner issues SINGLE -> grant sequence 001,010,100,001.
- Stall: HREADY held 0 for 3 cycles at M1's final beat of INCR8 -> HGRANT, HMASTER and HWDATA unchanged until HREADY=1.
- M2 HLOCK=1 over two INCR4 bursts with M0 requesting -> M0 granted only after M2 drops HLOCK and drives IDLE; HMASTLOCK=1 throughout the lock.
- HRESETn pulsed low mid-WRAP8 -> HGRANT=0 and HTRANS=IDLE immediately; normal arbitration resumes after release.
